// File: rtl/regfile_mp.sv
// regfile_mp -- parametrised multi-port register file with a busy-bit
// scoreboard and a sequential bulk-clear engine.
//
// Ports
//   clk          clock; every state update happens on the rising edge
//   rst          asynchronous active-high reset
//   rd_addr      NRD packed read addresses, port k at [k*AW +: AW]
//   rd_dout      NRD packed read data, port k at [k*WIDTH +: WIDTH]
//   rd_busy      scoreboard busy bit of each rd_addr
//   we           NWR write enables (a higher index wins on the same address)
//   wr_addr      NWR packed write addresses
//   wr_din       NWR packed write data
//   sb_set_en    mark sb_set_addr busy (producer issued)
//   sb_set_addr  register to mark busy
//   clr_req      bulk clear request, level, sampled in IDLE
//   clr_busy     bulk clear in progress
//   clr_done     one-cycle pulse once the clear has finished
module regfile_mp #(
   parameter int unsigned WIDTH    = 32,
   parameter int unsigned DEPTH    = 32,
   parameter int unsigned NRD      = 2,
   parameter int unsigned NWR      = 2,
   parameter int unsigned BYPASS   = 1,
   parameter int unsigned ZERO_REG = 1,
   localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NRD*AW-1:0]      rd_addr,
   output logic [NRD*WIDTH-1:0]   rd_dout,
   output logic [NRD-1:0]         rd_busy,
   input  logic [NWR-1:0]         we,
   input  logic [NWR*AW-1:0]      wr_addr,
   input  logic [NWR*WIDTH-1:0]   wr_din,
   input  logic                   sb_set_en,
   input  logic [AW-1:0]          sb_set_addr,
   input  logic                   clr_req,
   output logic                   clr_busy,
   output logic                   clr_done
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CLEAR = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t              state_q;
   logic [AW-1:0]       ptr_q;
   logic                clr_busy_q;
   logic                clr_done_q;

   logic [WIDTH-1:0]    mem_q  [DEPTH];
   logic [WIDTH-1:0]    mem_d  [DEPTH];
   logic                busy_q [DEPTH];
   logic                busy_d [DEPTH];

   logic [AW-1:0]       wa     [NWR];
   logic [WIDTH-1:0]    wd     [NWR];
   logic [NWR-1:0]      wr_ok;
   logic                sb_ok;

   function automatic logic in_range(input logic [AW-1:0] a);
      return 32'(a) < DEPTH;
   endfunction

   function automatic logic is_zero_reg(input logic [AW-1:0] a);
      return (ZERO_REG != 0) && (a == '0);
   endfunction

   // Write acceptance: not during a clear, address in range and not a
   // hardwired x0. The same qualifier gates the bypass path.
   always_comb begin
      wr_ok = '0;
      for (int unsigned j = 0; j < NWR; j++) begin
         wa[j]    = wr_addr[j*AW +: AW];
         wd[j]    = wr_din[j*WIDTH +: WIDTH];
         wr_ok[j] = we[j] && !clr_busy_q && in_range(wa[j]) && !is_zero_reg(wa[j]);
      end
      sb_ok = sb_set_en && !clr_busy_q && in_range(sb_set_addr) && !is_zero_reg(sb_set_addr);
   end

   // Next-state of the array and scoreboard. Ports are applied in ascending
   // order so the highest index wins; the busy set is applied last so a set
   // beats a same-cycle clear from a write.
   always_comb begin
      mem_d  = mem_q;
      busy_d = busy_q;
      if (clr_busy_q) begin
         if (in_range(ptr_q)) begin
            mem_d[ptr_q]  = '0;
            busy_d[ptr_q] = 1'b0;
         end
      end else begin
         for (int unsigned j = 0; j < NWR; j++) begin
            if (wr_ok[j]) begin
               mem_d[wa[j]]  = wd[j];
               busy_d[wa[j]] = 1'b0;
            end
         end
         if (sb_ok) begin
            busy_d[sb_set_addr] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q  <= '{default: '0};
         busy_q <= '{default: 1'b0};
      end else begin
         mem_q  <= mem_d;
         busy_q <= busy_d;
      end
   end

   // Bulk clear FSM. clr_busy is high exactly while in CLEAR, so the write,
   // scoreboard and bypass gating can use the registered flag directly.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         ptr_q      <= '0;
         clr_busy_q <= 1'b0;
         clr_done_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               clr_done_q <= 1'b0;
               if (clr_req) begin
                  state_q    <= ST_CLEAR;
                  ptr_q      <= '0;
                  clr_busy_q <= 1'b1;
               end
            end
            ST_CLEAR: begin
               if (ptr_q == AW'(DEPTH - 1)) begin
                  state_q    <= ST_DONE;
                  clr_busy_q <= 1'b0;
                  clr_done_q <= 1'b1;
               end else begin
                  ptr_q <= ptr_q + 1'b1;
               end
            end
            ST_DONE: begin
               state_q    <= ST_IDLE;
               clr_done_q <= 1'b0;
            end
            default: begin
               state_q    <= ST_IDLE;
               clr_busy_q <= 1'b0;
               clr_done_q <= 1'b0;
            end
         endcase
      end
   end

   assign clr_busy = clr_busy_q;
   assign clr_done = clr_done_q;

   // Combinational read ports. The bypass scan runs in ascending port order
   // so the highest matching accepted write supplies the data.
   always_comb begin
      rd_dout = '0;
      rd_busy = '0;
      for (int unsigned k = 0; k < NRD; k++) begin
         logic [AW-1:0]    ra;
         logic [WIDTH-1:0] v;
         ra = rd_addr[k*AW +: AW];
         v  = '0;
         if (in_range(ra)) begin
            v          = mem_q[ra];
            rd_busy[k] = busy_q[ra];
         end
         if (BYPASS != 0) begin
            for (int unsigned j = 0; j < NWR; j++) begin
               if (wr_ok[j] && (wa[j] == ra)) begin
                  v = wd[j];
               end
            end
         end
         if (is_zero_reg(ra)) begin
            v          = '0;
            rd_busy[k] = 1'b0;
         end
         rd_dout[k*WIDTH +: WIDTH] = v;
      end
   end

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

   logic          clk;
   logic          rst;
   logic [9:0]    rd_addr;
   logic [63:0]   rd_dout;
   logic [1:0]    rd_busy;
   logic [1:0]    we;
   logic [9:0]    wr_addr;
   logic [63:0]   wr_din;
   logic          sb_set_en;
   logic [4:0]    sb_set_addr;
   logic          clr_req;
   logic          clr_busy;
   logic          clr_done;

   int n_pass;
   int n_total;

   regfile_mp #(
      .WIDTH(32), .DEPTH(32), .NRD(2), .NWR(2), .BYPASS(1), .ZERO_REG(1)
   ) dut (
      .clk(clk), .rst(rst),
      .rd_addr(rd_addr), .rd_dout(rd_dout), .rd_busy(rd_busy),
      .we(we), .wr_addr(wr_addr), .wr_din(wr_din),
      .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr),
      .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change 1 time unit after a rising edge; outputs are checked
   // after a further settle step, well away from the next edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      we = '0;
      sb_set_en = 1'b0;
      clr_req = 1'b0;
   endtask

   task automatic set_rd(input int k, input logic [4:0] a);
      rd_addr[k*5 +: 5] = a;
   endtask

   task automatic set_wr(input int j, input logic [4:0] a, input logic [31:0] d);
      we[j] = 1'b1;
      wr_addr[j*5 +: 5] = a;
      wr_din[j*32 +: 32] = d;
   endtask

   function automatic logic [31:0] rd(input int k);
      return rd_dout[k*32 +: 32];
   endfunction

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
      else n_pass++;
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %b expected %b", name, act, exp);
      else n_pass++;
   endtask

   task automatic test_reset();
      for (int i = 1; i < 32; i++) begin
         idle_in();
         set_wr(0, 5'(i), 32'(i));
         tick();
      end
      idle_in();
      set_rd(0, 5'd31);
      set_rd(1, 5'd17);
      #1;
      chk32("pre_reset_x31", rd(0), 32'd31);
      chk32("pre_reset_x17", rd(1), 32'd17);
      rst = 1'b1;
      #1;
      chk32("async_reset_x31", rd(0), 32'd0);
      #1;
      rst = 1'b0;
      for (int i = 0; i < 32; i++) begin
         set_rd(0, 5'(i));
         #1;
         chk32($sformatf("reset_dout_x%0d", i), rd(0), 32'd0);
         chk1($sformatf("reset_busy_x%0d", i), rd_busy[0], 1'b0);
      end
      chk1("reset_clr_busy", clr_busy, 1'b0);
      chk1("reset_clr_done", clr_done, 1'b0);
      tick();
   endtask

   task automatic test_priority_bypass();
      idle_in();
      set_wr(0, 5'd5, 32'h0000AAAA);
      set_wr(1, 5'd5, 32'h00005555);
      set_rd(0, 5'd5);
      set_rd(1, 5'd6);
      #1;
      chk32("bypass_prio_same_cycle", rd(0), 32'h00005555);
      chk32("bypass_other_addr_stored", rd(1), 32'h0);
      tick();
      idle_in();
      #1;
      chk32("prio_stored_x5", rd(0), 32'h00005555);
      set_wr(0, 5'd6, 32'h00001234);
      #1;
      chk32("bypass_port0_x6", rd(1), 32'h00001234);
      tick();
      idle_in();
      #1;
      chk32("stored_x6", rd(1), 32'h00001234);
   endtask

   task automatic test_zero_reg();
      idle_in();
      set_wr(1, 5'd0, 32'hDEADBEEF);
      sb_set_en = 1'b1;
      sb_set_addr = 5'd0;
      set_rd(0, 5'd0);
      #1;
      chk32("zero_bypass_blocked", rd(0), 32'h0);
      tick();
      idle_in();
      #1;
      chk32("zero_read", rd(0), 32'h0);
      chk1("zero_busy", rd_busy[0], 1'b0);
   endtask

   task automatic test_scoreboard();
      idle_in();
      sb_set_en = 1'b1;
      sb_set_addr = 5'd7;
      set_rd(0, 5'd7);
      set_rd(1, 5'd8);
      #1;
      chk1("sb_not_bypassed", rd_busy[0], 1'b0);
      tick();
      idle_in();
      #1;
      chk1("sb_set_x7", rd_busy[0], 1'b1);
      chk1("sb_x8_clear", rd_busy[1], 1'b0);
      set_wr(0, 5'd7, 32'h00000077);
      sb_set_en = 1'b1;
      sb_set_addr = 5'd7;
      tick();
      idle_in();
      #1;
      chk1("sb_set_beats_clear", rd_busy[0], 1'b1);
      set_wr(1, 5'd7, 32'h00000078);
      tick();
      idle_in();
      #1;
      chk1("sb_write_clears", rd_busy[0], 1'b0);
      chk32("sb_write_data", rd(0), 32'h00000078);
   endtask

   task automatic test_back_to_back();
      idle_in();
      set_wr(0, 5'd10, 32'h0000000A);
      set_wr(1, 5'd11, 32'h0000000B);
      tick();
      idle_in();
      set_wr(1, 5'd10, 32'h0000000C);
      set_rd(0, 5'd10);
      set_rd(1, 5'd11);
      #1;
      chk32("b2b_bypass_x10", rd(0), 32'h0000000C);
      chk32("b2b_stored_x11", rd(1), 32'h0000000B);
      tick();
      idle_in();
      #1;
      chk32("b2b_stored_x10", rd(0), 32'h0000000C);
   endtask

   task automatic test_clear();
      int busy_cnt;
      int done_cnt;
      int bad;
      for (int i = 0; i < 32; i += 2) begin
         idle_in();
         set_wr(0, 5'(i), 32'hFFFFFFFF);
         set_wr(1, 5'(i + 1), 32'hFFFFFFFF);
         tick();
      end
      idle_in();
      sb_set_en = 1'b1;
      sb_set_addr = 5'd9;
      tick();
      idle_in();
      set_rd(0, 5'd9);
      #1;
      chk32("fill_x9", rd(0), 32'hFFFFFFFF);
      chk1("fill_busy_x9", rd_busy[0], 1'b1);
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      busy_cnt = clr_busy ? 1 : 0;
      done_cnt = clr_done ? 1 : 0;
      set_wr(0, 5'd3, 32'h00003333);
      set_rd(1, 5'd3);
      #1;
      chk32("clear_no_bypass", rd(1), 32'hFFFFFFFF);
      tick();
      idle_in();
      if (clr_busy) busy_cnt++;
      if (clr_done) done_cnt++;
      for (int c = 0; c < 40; c++) begin
         tick();
         if (clr_busy) busy_cnt++;
         if (clr_done) done_cnt++;
      end
      n_total++;
      if (busy_cnt != 32) $display("FAIL clear_busy_cycles: got %0d expected 32", busy_cnt);
      else n_pass++;
      n_total++;
      if (done_cnt != 1) $display("FAIL clear_done_pulses: got %0d expected 1", done_cnt);
      else n_pass++;
      bad = 0;
      for (int i = 0; i < 32; i++) begin
         set_rd(0, 5'(i));
         #1;
         if (rd(0) !== 32'h0 || rd_busy[0] !== 1'b0) bad++;
      end
      n_total++;
      if (bad != 0) $display("FAIL clear_array_zero: got %0d nonzero regs expected 0", bad);
      else n_pass++;
      set_rd(1, 5'd3);
      #1;
      chk32("clear_write_lost_x3", rd(1), 32'h0);
   endtask

   task automatic test_abort();
      int done_cnt;
      idle_in();
      set_wr(0, 5'd20, 32'h00002020);
      set_wr(1, 5'd1, 32'h00000101);
      tick();
      idle_in();
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      for (int c = 1; c < 10; c++) tick();
      chk1("abort_busy_before", clr_busy, 1'b1);
      rst = 1'b1;
      #1;
      chk1("abort_busy_now", clr_busy, 1'b0);
      set_rd(0, 5'd20);
      set_rd(1, 5'd1);
      #1;
      chk32("abort_x20_zero", rd(0), 32'h0);
      chk32("abort_x1_zero", rd(1), 32'h0);
      rst = 1'b0;
      done_cnt = 0;
      for (int c = 0; c < 40; c++) begin
         tick();
         if (clr_done || clr_busy) done_cnt++;
      end
      n_total++;
      if (done_cnt != 0) $display("FAIL abort_no_done: got %0d active cycles expected 0", done_cnt);
      else n_pass++;
      set_wr(0, 5'd4, 32'h00000044);
      tick();
      idle_in();
      set_rd(0, 5'd4);
      #1;
      chk32("abort_idle_write", rd(0), 32'h00000044);
   endtask

   initial begin
      n_pass = 0;
      n_total = 0;
      rst = 1'b1;
      rd_addr = '0;
      wr_addr = '0;
      wr_din = '0;
      sb_set_addr = '0;
      idle_in();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      test_reset();
      test_priority_bypass();
      test_zero_reg();
      test_scoreboard();
      test_back_to_back();
      test_clear();
      test_abort();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
